pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/adder_pkg.sv | 23 ++
 rtl/adder_slice.sv | 28 ++
 rtl/pipelined_adder.sv | 110 +++++++++++
 tb/tb_pipelined_adder.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants, stage record and full-adder cell for the pipelined adder.
// Stage records are sized for the widest supported adder; narrower adders use the low bits.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;
  localparam int MAX_WIDTH      = 64;

  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [MAX_WIDTH-1:0] a_rem;
    logic [MAX_WIDTH-1:0] b_rem;
    logic [MAX_WIDTH-1:0] psum;
    logic                 msb_carry;
  } stage_rec_t;

  // Returns {carry_out, sum_bit}
  function automatic logic [1:0] full_adder(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational ripple adder for one pipeline slice, chained from full-adder cells.
// Also exposes the carry into its MSB so the last slice can flag signed overflow.
module adder_slice
  import adder_pkg::*;
#(
  parameter int SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          msb_cin
);

  always_comb begin
    logic c;
    c       = cin;
    sum     = '0;
    msb_cin = cin;
    for (int i = 0; i < SW; i++) begin
      if (i == SW - 1) msb_cin = c;
      {c, sum[i]} = full_adder(a[i], b[i], c);
    end
    cout = c;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract pipeline: stage k adds slice k with the carry registered by stage k-1,
// and a per-stage valid bit with a combinational ready chain gives full-rate flow control.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;

  if (STAGES < 1 || (WIDTH % STAGES) != 0 || WIDTH > MAX_WIDTH) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH (%0d) must be a multiple of STAGES (%0d) and at most %0d",
           WIDTH, STAGES, MAX_WIDTH);
  end

  stage_rec_t stage_q [STAGES];
  stage_rec_t src     [STAGES];
  stage_rec_t nxt     [STAGES];
  stage_rec_t in_rec;

  logic [STAGES-1:0]         load;
  logic [STAGES-1:0][SW-1:0] sl_a;
  logic [STAGES-1:0][SW-1:0] sl_b;
  logic [STAGES-1:0][SW-1:0] sl_sum;
  logic [STAGES-1:0]         sl_cin;
  logic [STAGES-1:0]         sl_cout;
  logic [STAGES-1:0]         sl_msb;

  // Subtraction becomes a + ~b + 1, so cin is replaced by a forced carry of 1
  always_comb begin
    in_rec                  = '0;
    in_rec.valid            = in_valid;
    in_rec.carry            = sub ? 1'b1 : cin;
    in_rec.a_rem[WIDTH-1:0] = a;
    in_rec.b_rem[WIDTH-1:0] = sub ? ~b : b;
  end

  always_comb begin
    src[0] = in_rec;
    for (int k = 1; k < STAGES; k++) src[k] = stage_q[k-1];
    for (int k = 0; k < STAGES; k++) begin
      sl_a[k]   = src[k].a_rem[k*SW +: SW];
      sl_b[k]   = src[k].b_rem[k*SW +: SW];
      sl_cin[k] = src[k].carry;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(.SW(SW)) u_slice (
      .a      (sl_a[k]),
      .b      (sl_b[k]),
      .cin    (sl_cin[k]),
      .sum    (sl_sum[k]),
      .cout   (sl_cout[k]),
      .msb_cin(sl_msb[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nxt[k]                     = src[k];
      nxt[k].carry               = sl_cout[k];
      nxt[k].msb_carry           = sl_msb[k];
      nxt[k].psum[k*SW +: SW]    = sl_sum[k];
    end
  end

  // A stage may load when it is empty or when its successor makes room this cycle
  always_comb begin
    logic room;
    room = out_ready;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      room    = !stage_q[k].valid || room;
      load[k] = room;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) stage_q[k] <= nxt[k];
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = stage_q[STAGES-1].valid;
  assign sum       = stage_q[STAGES-1].psum[WIDTH-1:0];
  assign cout      = stage_q[STAGES-1].carry;
  assign ovf       = stage_q[STAGES-1].msb_carry ^ stage_q[STAGES-1].carry;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: a signed/unsigned arithmetic model feeds an
// expected-result queue that an independent output monitor drains and compares.
module tb_pipelined_adder;

  localparam int     WIDTH   = 16;
  localparam int     STAGES  = 4;
  localparam int     TIMEOUT = 200;
  localparam longint MODV    = longint'(1) << WIDTH;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } result_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  result_t exp_q[$];
  int      checks    = 0;
  int      errors    = 0;
  int      cycle     = 0;
  int      in_count  = 0;
  int      out_count = 0;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference: exact integer arithmetic, signed overflow judged against the signed range
  function automatic result_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic c, input logic s);
    longint  ux, uy, sx, sy, ures, sres;
    result_t r;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      ures   = ux - uy;
      sres   = sx - sy;
      r.cout = (ux >= uy);
    end else begin
      ures   = ux + uy + longint'(c);
      sres   = sx + sy + longint'(c);
      r.cout = (ures >= MODV);
    end
    r.sum = ures[WIDTH-1:0];
    r.ovf = (sres >= MODV / 2) || (sres < -(MODV / 2));
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(WIDTH-1){1'b0}}};
      3:       return {1'b0, {(WIDTH-1){1'b1}}};
      default: return WIDTH'($urandom);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cycle);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                               input logic tcin, input logic tsub, output int waited);
    logic took;
    logic done;
    waited   = 0;
    done     = 1'b0;
    a        = ta;
    b        = tb;
    cin      = tcin;
    sub      = tsub;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) begin
        done = 1'b1;
      end else begin
        waited++;
        if (waited > TIMEOUT) begin
          checkOutput("input accept timeout", 64'd0, 64'd1);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(model(a, b, cin, sub));
      in_count++;
    end
  end

  always @(negedge clk) begin : out_monitor
    result_t r;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected out_valid", 64'(out_valid), 64'd0);
      end else begin
        r = exp_q[0];
        checkOutput("sum", 64'(sum), 64'(r.sum));
        checkOutput("cout", 64'(cout), 64'(r.cout));
        checkOutput("ovf", 64'(ovf), 64'(r.ovf));
        if (out_ready) begin
          void'(exp_q.pop_front());
          out_count++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  waited;
    int  stall_total;
    int  accept_edge;
    int  base_out;
    int  base_in;
    int  held;
    int  gap;
    logic seen;
    logic saw_block;
    logic rand_done;

    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 16'h1234;
    b         = 16'h4321;
    cin       = 1'b1;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset sum", 64'(sum), 64'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("in_ready after reset", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Carry ripples through every stage; also measures first-result latency
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, waited);
    accept_edge = cycle;
    in_valid    = 1'b0;
    seen        = 1'b0;
    for (int i = 0; i < TIMEOUT && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkOutput("first result seen", 64'(seen), 64'd1);
    checkOutput("first result latency", 64'(cycle + 1 - accept_edge), 64'(STAGES));
    wait_drain("drain after carry case");

    stall_total = 0;
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, waited);
    stall_total += waited;
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1, waited);
    stall_total += waited;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom), waited);
      stall_total += waited;
    end
    in_valid = 1'b0;
    checkOutput("full-rate input stalls", 64'(stall_total), 64'd0);
    wait_drain("drain after full-rate burst");

    // Back-pressure: 8 back-to-back inputs, out_ready low for 3 cycles after the 2nd result
    base_out  = out_count;
    base_in   = in_count;
    saw_block = 1'b0;
    held      = -1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          applyStimulus(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom), waited);
        end
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < TIMEOUT && out_count < base_out + 2; i++) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!in_ready && !saw_block) begin
            saw_block = 1'b1;
            held      = exp_q.size();
          end
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    checkOutput("in_ready drops when full", 64'(saw_block), 64'd1);
    checkOutput("transactions held when full", 64'(held), 64'(STAGES));
    wait_drain("drain after back-pressure");
    checkOutput("back-pressure outputs", 64'(out_count - base_out), 64'd8);
    checkOutput("back-pressure inputs", 64'(in_count - base_in), 64'd8);

    // Random operands, random gaps and random downstream stalls
    base_out  = out_count;
    base_in   = in_count;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          applyStimulus(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom), waited);
          gap = $urandom_range(0, 2);
          if (gap != 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
          end
        end
        in_valid  = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("drain after random traffic");
    checkOutput("random outputs", 64'(out_count - base_out), 64'(in_count - base_in));

    // Reset with three transactions in flight must discard them all
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom), waited);
    end
    in_valid = 1'b0;
    seen     = 1'b0;
    for (int i = 0; i < TIMEOUT && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkOutput("stalled result present", 64'(seen), 64'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("out_valid drops on reset", 64'(out_valid), 64'd0);
    checkOutput("sum cleared on reset", 64'(sum), 64'd0);
    checkOutput("ovf cleared on reset", 64'(ovf), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    base_out  = out_count;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("stale results after reset", 64'(out_count - base_out), 64'd0);

    applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, waited);
    in_valid = 1'b0;
    wait_drain("drain after reset recovery");
    checkOutput("recovery output", 64'(out_count - base_out), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
